// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 5-port mesh router:
//   - output port indices and the one-hot port vector type
//   - flit type codes carried in the two MSBs of every flit
//   - bit positions of the destination coordinates inside a flit
//   - xy_route: dimension-ordered (X first, then Y) routing decision
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  typedef logic [NUM_PORTS-1:0] port_vec_t;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  localparam int COORD_W    = 4;
  localparam int DEST_X_LSB = 4;
  localparam int DEST_Y_LSB = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } iu_state_e;

  // X is resolved completely before Y, which keeps the mesh deadlock free.
  function automatic port_vec_t xy_route(input logic [COORD_W-1:0] dest_x,
                                         input logic [COORD_W-1:0] dest_y,
                                         input logic [COORD_W-1:0] local_x,
                                         input logic [COORD_W-1:0] local_y);
    port_vec_t r;
    r = '0;
    if (dest_x > local_x) begin
      r[PORT_EAST] = 1'b1;
    end else if (dest_x < local_x) begin
      r[PORT_WEST] = 1'b1;
    end else if (dest_y > local_y) begin
      r[PORT_NORTH] = 1'b1;
    end else if (dest_y < local_y) begin
      r[PORT_SOUTH] = 1'b1;
    end else begin
      r[PORT_LOCAL] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// -----------------------------------------------------------------------------
// flit_fifo
// Synchronous FIFO with a first-word fall-through read port: the oldest entry
// is always visible on data_o while empty_o is low.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (flushes the FIFO)
//   push_i/data_i  write request and data (ignored while full)
//   pop_i          remove the front entry (ignored while empty)
//   data_o         front entry
//   full_o/empty_o occupancy flags
// -----------------------------------------------------------------------------
module flit_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              pop_i,
  output logic [FLIT_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  // The extra pointer MSB tells a full FIFO apart from an empty one when the
  // index bits coincide.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/router_input_unit.sv
// -----------------------------------------------------------------------------
// router_input_unit
// Input port of the mesh router: buffers flits, XY-routes each head flit,
// requests the matching output arbiter and forwards the whole wormhole packet
// once granted.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   in_valid   upstream flit valid;  in_flit upstream flit
//   in_ready   FIFO has room
//   req        one-hot output request (0 local, 1 N, 2 E, 3 S, 4 W)
//   grant      arbiter select vector, only the requested bit counts
//   out_valid  front flit offered to the requested/locked port
//   out_flit   FIFO front flit
//   arb_next   pulse when a packet's last flit transfers
//   err_drop   pulse when an orphan body/tail flit is discarded
// -----------------------------------------------------------------------------
module router_input_unit
  import router_pkg::*;
#(
  parameter int                 FLIT_W  = 32,
  parameter int                 DEPTH   = 4,
  parameter logic [COORD_W-1:0] LOCAL_X = 4'd0,
  parameter logic [COORD_W-1:0] LOCAL_Y = 4'd0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output port_vec_t         req,
  input  port_vec_t         grant,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic              arb_next,
  output logic              err_drop
);

  iu_state_e         state_q;
  port_vec_t         lock_port_q;

  logic [FLIT_W-1:0] front;
  logic              fifo_full;
  logic              fifo_empty;
  flit_type_e        front_type;
  logic              front_is_head;
  port_vec_t         route;
  logic              drop;
  logic              xfer;

  flit_fifo #(
    .FLIT_W(FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (in_valid),
    .data_i (in_flit),
    .pop_i  (xfer || drop),
    .data_o (front),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign front_type    = flit_type_e'(front[FLIT_W-1:FLIT_W-2]);
  assign front_is_head = (front_type == FT_HEAD) || (front_type == FT_SINGLE);
  assign route         = xy_route(front[DEST_X_LSB +: COORD_W],
                                  front[DEST_Y_LSB +: COORD_W],
                                  LOCAL_X, LOCAL_Y);

  // In LOCKED the request is held even with an empty FIFO so the output port
  // stays owned across upstream bubbles; in IDLE orphans are flushed.
  always_comb begin
    req  = '0;
    drop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (front_is_head) req  = route;
          else               drop = 1'b1;
        end
      end
      ST_LOCKED: req = lock_port_q;
      default:   req = '0;
    endcase
  end

  assign out_valid = !fifo_empty && (|req);
  assign xfer      = out_valid && (|(grant & req));
  assign out_flit  = front;
  assign in_ready  = !fifo_full;
  assign err_drop  = drop;

  // Inside a locked packet only a tail ends it; heads are forwarded as body.
  assign arb_next = xfer && (((state_q == ST_IDLE)   && (front_type == FT_SINGLE)) ||
                             ((state_q == ST_LOCKED) && (front_type == FT_TAIL)));

  // Packet ownership state machine.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      lock_port_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer && (front_type == FT_HEAD)) begin
            state_q     <= ST_LOCKED;
            lock_port_q <= route;
          end
        end
        ST_LOCKED: begin
          if (xfer && (front_type == FT_TAIL)) begin
            state_q     <= ST_IDLE;
            lock_port_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          lock_port_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_input_unit.sv
// -----------------------------------------------------------------------------
// tb_router_input_unit
// Randomised and directed stimulus for router_input_unit at LOCAL = (1,1).
// Every accepted flit is run through a packet-level reference model that
// pushes the expected outcome (forward to a port, or drop) into a queue; a
// monitor compares the DUT's outputs against the queue front every cycle.
// -----------------------------------------------------------------------------
module tb_router_input_unit;

  localparam int FW    = 32;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_flit = '0;
  logic        in_ready;
  logic [4:0]  req;
  logic [4:0]  grant = '0;
  logic        out_valid;
  logic [31:0] out_flit;
  logic        arb_next;
  logic        err_drop;

  router_input_unit #(
    .FLIT_W (FW),
    .DEPTH  (DEPTH),
    .LOCAL_X(4'd1),
    .LOCAL_Y(4'd1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_flit  (in_flit),
    .in_ready (in_ready),
    .req      (req),
    .grant    (grant),
    .out_valid(out_valid),
    .out_flit (out_flit),
    .arb_next (arb_next),
    .err_drop (err_drop)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          drop;
    logic [31:0] flit;
    logic [4:0]  port;
    bit          last;
  } exp_t;

  exp_t       expQ[$];
  bit         inPkt = 1'b0;
  logic [4:0] pktPort = '0;
  int         checks = 0;
  int         errors = 0;
  bit         monEn = 1'b0;
  bit         randGrant = 1'b0;
  logic [4:0] grantFixed = '0;
  exp_t       monE;
  bit         monXfer;

  // Router sits at (1,1): one-hot port from plain coordinate comparison.
  function automatic logic [4:0] refRoute(input int dx, input int dy);
    if (dx > 1) return 5'b00100;
    if (dx < 1) return 5'b10000;
    if (dy > 1) return 5'b00010;
    if (dy < 1) return 5'b01000;
    return 5'b00001;
  endfunction

  // Packet-level model: decides for each accepted flit whether it will be
  // forwarded (and where, and whether it closes the packet) or dropped.
  function automatic void modelAccept(input logic [31:0] f);
    exp_t e;
    int   t;
    t      = int'(f[31:30]);
    e.flit = f;
    e.drop = 1'b0;
    e.last = 1'b0;
    e.port = '0;
    if (inPkt) begin
      e.port = pktPort;
      e.last = (t == 2);
      if (t == 2) inPkt = 1'b0;
    end else if (t == 1 || t == 3) begin
      e.port = refRoute(int'(f[7:4]), int'(f[3:0]));
      e.last = (t == 3);
      if (t == 1) begin
        inPkt   = 1'b1;
        pktPort = e.port;
      end
    end else begin
      e.drop = 1'b1;
    end
    expQ.push_back(e);
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] x, input logic [3:0] y);
    logic [21:0] pay;
    pay = 22'($urandom);
    return {t, pay, x, y};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic applyStimulus(input bit v, input logic [31:0] f, output bit acc);
    in_valid = v;
    in_flit  = f;
    grant    = randGrant ? 5'($urandom_range(0, 31)) : grantFixed;
    @(negedge CLK);
    acc = v && in_ready;
    @(posedge CLK);
    if (acc) modelAccept(f);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendFlit(input logic [31:0] f);
    bit acc;
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, f, acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  task automatic idleCycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, acc);
  endtask

  task automatic resetDut();
    in_valid = 1'b0;
    grantFixed = '0;
    grant    = '0;
    RST      = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    expQ.delete();
    inPkt   = 1'b0;
    pktPort = '0;
  endtask

  // Monitor: compares DUT outputs with the scoreboard front every cycle.
  always @(negedge CLK) begin
    if (monEn && !RST) begin
      checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() < DEPTH));
      if (expQ.size() == 0) begin
        checkOutput("req_empty", 32'(req), 32'(inPkt ? pktPort : 5'b0));
        checkOutput("out_valid_empty", 32'(out_valid), 32'd0);
        checkOutput("arb_next_empty", 32'(arb_next), 32'd0);
        checkOutput("err_drop_empty", 32'(err_drop), 32'd0);
      end else begin
        monE = expQ[0];
        if (monE.drop) begin
          checkOutput("err_drop", 32'(err_drop), 32'd1);
          checkOutput("req_drop", 32'(req), 32'd0);
          checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
          checkOutput("arb_next_drop", 32'(arb_next), 32'd0);
          void'(expQ.pop_front());
        end else begin
          monXfer = |(grant & monE.port);
          checkOutput("out_valid", 32'(out_valid), 32'd1);
          checkOutput("req", 32'(req), 32'(monE.port));
          checkOutput("out_flit", out_flit, monE.flit);
          checkOutput("err_drop_fwd", 32'(err_drop), 32'd0);
          checkOutput("arb_next", 32'(arb_next), 32'(monXfer && monE.last));
          if (monXfer) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    bit acc;
    int nb;
    int n;
    repeat (2) @(posedge CLK);
    #1;
    RST   = 1'b0;
    monEn = 1'b1;
    idleCycles(1);

    // Head to (3,1) -> east, then body and tail with the grant held.
    grantFixed = 5'b00100;
    sendFlit(mk(2'b01, 4'd3, 4'd1));
    sendFlit(mk(2'b00, 4'd3, 4'd1));
    sendFlit(mk(2'b10, 4'd3, 4'd1));
    idleCycles(2);

    // Single-flit packet to local, grant arrives 3 cycles late.
    grantFixed = 5'b00000;
    sendFlit(mk(2'b11, 4'd1, 4'd1));
    idleCycles(3);
    grantFixed = 5'b00001;
    idleCycles(2);

    // Head to (1,0) -> south, upstream stall of 2 cycles inside the packet.
    grantFixed = 5'b01000;
    sendFlit(mk(2'b01, 4'd1, 4'd0));
    idleCycles(2);
    sendFlit(mk(2'b00, 4'd1, 4'd0));
    sendFlit(mk(2'b10, 4'd1, 4'd0));
    idleCycles(2);

    // Orphan body as first flit after reset.
    resetDut();
    sendFlit(mk(2'b00, 4'd2, 4'd2));
    idleCycles(2);

    // Fill the FIFO with grant low, fifth flit must be refused.
    grantFixed = 5'b00000;
    sendFlit(mk(2'b01, 4'd0, 4'd1));
    sendFlit(mk(2'b00, 4'd0, 4'd1));
    sendFlit(mk(2'b00, 4'd0, 4'd1));
    sendFlit(mk(2'b00, 4'd0, 4'd1));
    applyStimulus(1'b1, mk(2'b10, 4'd0, 4'd1), acc);
    checkOutput("fifth_rejected", 32'(acc), 32'd0);
    grantFixed = 5'b10000;
    sendFlit(mk(2'b10, 4'd0, 4'd1));
    idleCycles(6);

    // Reset after the head has transferred, body still buffered.
    grantFixed = 5'b00100;
    sendFlit(mk(2'b01, 4'd3, 4'd1));
    sendFlit(mk(2'b00, 4'd3, 4'd1));
    resetDut();
    idleCycles(3);

    // Randomised packets with random grants and upstream gaps.
    randGrant = 1'b1;
    for (int p = 0; p < 300; p++) begin
      logic [3:0] dx;
      logic [3:0] dy;
      int kind;
      dx   = 4'($urandom_range(0, 3));
      dy   = 4'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        sendFlit(mk($urandom_range(0, 1) ? 2'b10 : 2'b00, dx, dy));
      end else if (kind < 3) begin
        sendFlit(mk(2'b11, dx, dy));
      end else begin
        sendFlit(mk(2'b01, dx, dy));
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(0, 3) == 0) idleCycles(1);
          sendFlit(mk(($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00, dx, dy));
        end
        sendFlit(mk(2'b10, dx, dy));
      end
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end

    // Drain whatever is still buffered.
    randGrant  = 1'b0;
    grantFixed = 5'h1F;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      idleCycles(1);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0", expQ.size());
    end
    idleCycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
